bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter W, default 8, is the binary input width (W >= 1).
REQ-002 Parameter D, default 3, is the number of BCD digits in the output (D >= 1).
REQ-003 Port clk, input, 1 bit, is the single clock; every register samples on its rising edge.
REQ-004 Port rst, input, 1 bit, is the reset: synchronous and active-high.
REQ-005 Port start, input, 1 bit, requests a conversion of bin.
REQ-006 Port bin, input, W bits, is the unsigned binary operand.
REQ-007 Port busy, output, 1 bit, is high while a conversion is in progress.
REQ-008 Port done, output, 1 bit, is a one-cycle pulse marking that bcd and overflow are valid.
REQ-009 Port bcd, output, 4*D bits, is the packed BCD result; digit 0 (ones) is in bits [3:0].
REQ-010 Port overflow, output, 1 bit, is high when the value exceeds 10^D-1.

Function
REQ-011 The algorithm is sequential shift-and-add-3 (double dabble), processing one bin bit per clock, MSB first.
REQ-012 The FSM has three states: IDLE, SHIFT and DONE.
REQ-013 IDLE or DONE with start=1 at edge t:
- latch bin into a shift register;
- clear the scratch digits and the overflow register;
- load the bit counter with W-1;
- go to SHIFT.
REQ-014 Every SHIFT cycle does two steps:
- each scratch digit >= 5 gets +3 (mod 16);
- then {digits, shift register} shifts left by 1.
REQ-015 In SHIFT, the counter decrements each cycle; a SHIFT cycle with counter=0 goes to DONE.
REQ-016 Latency: start sampled at edge t gives busy=1 for cycles t+1..t+W and done=1 in cycle t+W+1 only.
REQ-017 In DONE, done=1 and busy=0; DONE goes to IDLE when start=0.
REQ-018 bcd is updated only on the SHIFT->DONE transition, and holds its value until the next such transition.
REQ-019 overflow is a sticky flag for the conversion in progress:
- it is set if any bit is shifted out of the MS digit during the conversion;
- it is published together with bcd.
REQ-020 When overflow=1, the bcd content is the low D digits of the result, taken modulo 10^D.
REQ-021 start while busy=1 is ignored; bin changes while busy=1 have no effect on the result.
REQ-022 start asserted in the DONE cycle begins a new conversion, so back-to-back throughput is one result per W+1 cycles.
REQ-023 Each corrected digit is taken mod 16, and a correction carry never propagates into the next digit.

Reset
REQ-024 On rst=1 at a rising edge:
- state <= IDLE;
- busy, done and overflow <= 0;
- bcd, scratch digits, shift register and counter <= 0.
REQ-025 Reset during SHIFT aborts the conversion with no done pulse; bcd reads 0 in the cycle after the reset edge.
REQ-026 rst takes priority over start in the same cycle.

Structure
REQ-027 Package bin2bcd_pkg holds:
- the state enum (IDLE, SHIFT, DONE);
- constant BCD_DIGIT_W = 4;
- the add-3 threshold constant 5.
REQ-028 Sub-module add3_digit is combinational: 4-bit in, 4-bit out, in >= 5 ? in+3 : in. It is instantiated D times through a generate loop.
REQ-029 The counter width is $clog2(W) with a minimum of 1; no other arithmetic is wider than 4 bits.

Verification
REQ-030 W=8, D=3, bin=255, start at cycle 0 -> done at cycle 9, bcd=0x255, overflow=0.
REQ-031 W=8, D=3, bin=0 -> bcd=0x000 after 9 cycles; exhaustive sweep 0..255 matches a reference model, overflow always 0.
REQ-032 W=8, D=2, bin=100 -> bcd=0x00, overflow=1; bin=99 -> bcd=0x99, overflow=0.
REQ-033 W=8, D=3, bin=37, then start=1 with bin=200 at cycle 3 -> the second start is ignored; done once at cycle 9 with bcd=0x037.
REQ-034 rst=1 at cycle 4 of a conversion of bin=128 -> no done pulse, busy=0 and bcd=0 the next cycle; a new start then completes normally.
REQ-035 Back-to-back: start held high, bin=12 then bin=34 -> done at cycles 9 and 18, bcd=0x012 then 0x034.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  // Controller states of the converter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Digits at or above this value get +3 before each shift.
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Bit-counter width: enough to hold W-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Single-digit double-dabble correction: adds 3 to a digit of 5 or more.
// The sum wraps within the nibble, so no carry ever leaves this digit.
module add3_digit
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  // Conditional +3, kept strictly 4 bits wide.
  assign fixed = (digit >= ADD3_THRESH) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// MSB first. A result of W bits takes W SHIFT cycles plus one DONE cycle.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last published result
// SHIFT | correcting and shifting one operand bit per cycle (busy=1)
// DONE  | result just published, done=1; start here restarts directly
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [W-1:0]             bin,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_DIGIT_W*D-1:0] bcd,
  output logic                     overflow
);

  localparam int CW = cnt_width(W);
  localparam int DW = BCD_DIGIT_W * D;

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_SHIFT = 2'(SHIFT);
  localparam logic [1:0] S_DONE  = 2'(DONE);

  logic [1:0]      state;
  logic [W-1:0]    sr;
  logic [W-1:0]    sr_nxt;
  logic [DW-1:0]   dig;
  logic [DW-1:0]   dig_fix;
  logic [DW-1:0]   dig_nxt;
  logic [DW+W-1:0] cat_shl;
  logic [CW-1:0]   cnt;
  logic            ovf_acc;
  logic            carry;

  // Per-digit +3 correction ahead of the shift.
  for (genvar i = 0; i < D; i++) begin : g_add3
    add3_digit u_add3 (
      .digit (dig[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .fixed (dig_fix[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // Shift {corrected digits, operand} left by one; the bit falling off the
  // top digit is a whole unit of 10^D and therefore signals overflow.
  assign carry   = dig_fix[DW-1];
  assign cat_shl = {dig_fix, sr} << 1;
  assign dig_nxt = cat_shl[DW+W-1:W];
  assign sr_nxt  = cat_shl[W-1:0];

  // Controller, datapath registers and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      dig      <= '0;
      sr       <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
    end else begin
      case (state)
        S_SHIFT: begin
          dig     <= dig_nxt;
          sr      <= sr_nxt;
          ovf_acc <= ovf_acc | carry;
          if (cnt == '0) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= dig_nxt;
            overflow <= ovf_acc | carry;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // IDLE, DONE and any unreachable encoding all accept a new start.
        default: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            sr      <= bin;
            dig     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(W - 1);
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a D=3 instance checked every cycle
// against a timing/arithmetic model, and a D=2 instance for overflow cases.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  bin = '0;
  logic        busy, done, overflow;
  logic [11:0] bcd;

  logic        start2 = 1'b0;
  logic [7:0]  bin2 = '0;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_bad = 0;

  bin2bcd_seq #(.W(8), .D(3)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bin2bcd_seq #(.W(8), .D(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal value of v modulo 10^nd, packed as BCD digits.
  function automatic logic [31:0] ref_bcd(input int v, input int nd);
    logic [31:0] r;
    int m;
    int p;
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    m = v % p;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Behavioural model of the D=3 instance: a start accepted when not busy
  // yields busy for 8 cycles, then done for one cycle with the decimal result.
  int          m_left = 0;
  bit          m_done = 0;
  logic [11:0] m_bcd = '0;
  bit          m_ovf = 0;
  int          m_val = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 0; m_bcd = '0; m_ovf = 0; chk_en = 1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_bcd  = 12'(ref_bcd(m_val, 3));
        m_ovf  = (m_val > 999);
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_val  = int'(bin);
        m_left = 8;
      end
    end
    #1;
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_left > 0));
      check("model_done", 32'(done), 32'(m_done));
      check("model_bcd", 32'(bcd), 32'(m_bcd));
      check("model_ovf", 32'(overflow), 32'(m_ovf));
    end
  end

  // One conversion on the D=3 instance; bin is scrambled while busy.
  task automatic conv(input logic [7:0] v, input logic [11:0] exp, input string name);
    int k;
    bit got;
    @(negedge clk);
    start = 1'b1; bin = v;
    k = 0; got = 0;
    while (k < 30 && !got) begin
      @(negedge clk);
      start = 1'b0;
      bin = 8'($urandom);
      k++;
      if (done) got = 1;
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    check({name, "_lat"}, 32'(k), 32'd9);
    check({name, "_bcd"}, 32'(bcd), 32'(exp));
    check({name, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  task automatic conv2(input logic [7:0] v, input logic [7:0] exp, input bit exp_ovf, input string name);
    int k;
    bit got;
    @(negedge clk);
    start2 = 1'b1; bin2 = v;
    k = 0; got = 0;
    while (k < 30 && !got) begin
      @(negedge clk);
      start2 = 1'b0;
      k++;
      if (done2) got = 1;
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    check({name, "_lat"}, 32'(k), 32'd9);
    check({name, "_bcd"}, 32'(bcd2), 32'(exp));
    check({name, "_ovf"}, 32'(overflow2), 32'(exp_ovf));
  endtask

  initial begin
    int k;
    int nd;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd2", 32'(bcd2), 32'd0);

    // Hand-computed anchors.
    conv(8'd255, 12'h255, "c255");
    conv(8'd0, 12'h000, "c0");
    conv(8'd9, 12'h009, "c9");
    conv(8'd10, 12'h010, "c10");
    conv(8'd199, 12'h199, "c199");

    // Overflow on two digits.
    conv2(8'd100, 8'h00, 1'b1, "d2_100");
    conv2(8'd99, 8'h99, 1'b0, "d2_99");
    conv2(8'd255, 8'h55, 1'b1, "d2_255");

    // A start while busy is ignored.
    @(negedge clk);
    start = 1'b1; bin = 8'd37;
    k = 0; nd = 0;
    while (k < 15) begin
      @(negedge clk);
      k++;
      start = (k == 3);
      bin = (k == 3) ? 8'd200 : 8'd37;
      if (done) begin
        nd++;
        check("ign_lat", 32'(k), 32'd9);
        check("ign_bcd", 32'(bcd), 32'h037);
      end
    end
    check("ign_count", 32'(nd), 32'd1);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1; bin = 8'd128;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);
    conv(8'd128, 12'h128, "c128");

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; bin = 8'd12;
    k = 0; nd = 0;
    while (k < 25 && nd < 2) begin
      @(negedge clk);
      k++;
      bin = 8'd34;
      if (done) begin
        nd++;
        if (nd == 1) begin
          check("b2b_lat1", 32'(k), 32'd9);
          check("b2b_bcd1", 32'(bcd), 32'h012);
        end else begin
          check("b2b_lat2", 32'(k), 32'd18);
          check("b2b_bcd2", 32'(bcd), 32'h034);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(nd), 32'd2);
    repeat (3) @(negedge clk);

    // Exhaustive sweep against the decimal reference.
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), 12'(ref_bcd(v, 3)), "sweep");
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
